// File: rtl/axil_cfg_master.sv
// axil_cfg_master: turns one command at a time into an AXI-Lite write or read.
// Only one transaction is outstanding. Waiting for B or R is bounded by
// TIMEOUT_CYCLES, and a timed-out wait is reported as SLVERR with rsp_timeout set.
module axil_cfg_master #(
    parameter int AXIL_ADDR_WIDTH = 40,
    parameter int DATA_WIDTH      = 32,
    parameter int STRB_WIDTH      = DATA_WIDTH/8,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_we,
    input  logic [AXIL_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]      cmd_wdata,
    input  logic [STRB_WIDTH-1:0]      cmd_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic [1:0]                 rsp_resp,
    output logic                       rsp_timeout,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_awaddr,
    output logic [2:0]                 m_axil_awprot,
    output logic                       m_axil_awvalid,
    input  logic                       m_axil_awready,
    output logic [DATA_WIDTH-1:0]      m_axil_wdata,
    output logic [STRB_WIDTH-1:0]      m_axil_wstrb,
    output logic                       m_axil_wvalid,
    input  logic                       m_axil_wready,
    input  logic [1:0]                 m_axil_bresp,
    input  logic                       m_axil_bvalid,
    output logic                       m_axil_bready,
    output logic [AXIL_ADDR_WIDTH-1:0] m_axil_araddr,
    output logic [2:0]                 m_axil_arprot,
    output logic                       m_axil_arvalid,
    input  logic                       m_axil_arready,
    input  logic [DATA_WIDTH-1:0]      m_axil_rdata,
    input  logic [1:0]                 m_axil_rresp,
    input  logic                       m_axil_rvalid,
    output logic                       m_axil_rready
);

    typedef enum logic [2:0] {
        IDLE, WR_ADDR_DATA, WAIT_B, RD_ADDR, WAIT_R, RSP
    } state_t;

    typedef struct packed {
        logic [AXIL_ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]      wdata;
        logic [STRB_WIDTH-1:0]      wstrb;
    } cmd_t;

    // Last wait cycle that may still carry a handshake; after it the wait times out.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    cmd_t        cmd_q;
    logic [15:0] wait_cnt;

    logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic aw_done, w_done;

    assign aw_hs = m_axil_awvalid & m_axil_awready;
    assign w_hs  = m_axil_wvalid  & m_axil_wready;
    assign b_hs  = m_axil_bvalid  & m_axil_bready;
    assign ar_hs = m_axil_arvalid & m_axil_arready;
    assign r_hs  = m_axil_rvalid  & m_axil_rready;

    // A write channel is finished once its valid has dropped or is handshaking now.
    assign aw_done = !m_axil_awvalid || aw_hs;
    assign w_done  = !m_axil_wvalid  || w_hs;

    // Payload comes straight from the captured command, so it stays stable while valid is high.
    assign m_axil_awaddr = cmd_q.addr;
    assign m_axil_araddr = cmd_q.addr;
    assign m_axil_wdata  = cmd_q.wdata;
    assign m_axil_wstrb  = cmd_q.wstrb;
    assign m_axil_awprot = 3'b000;
    assign m_axil_arprot = 3'b000;

    // Transaction FSM. Every handshake and response output is a register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state          <= IDLE;
            cmd_q          <= '0;
            cmd_ready      <= 1'b0;
            m_axil_awvalid <= 1'b0;
            m_axil_wvalid  <= 1'b0;
            m_axil_bready  <= 1'b0;
            m_axil_arvalid <= 1'b0;
            m_axil_rready  <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_resp       <= 2'b00;
            rsp_rdata      <= '0;
            rsp_timeout    <= 1'b0;
            wait_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        cmd_q     <= '{addr: cmd_addr, wdata: cmd_wdata, wstrb: cmd_wstrb};
                        if (cmd_we) begin
                            m_axil_awvalid <= 1'b1;
                            m_axil_wvalid  <= 1'b1;
                            state          <= WR_ADDR_DATA;
                        end else begin
                            m_axil_arvalid <= 1'b1;
                            state          <= RD_ADDR;
                        end
                    end
                end
                WR_ADDR_DATA: begin
                    if (aw_hs) m_axil_awvalid <= 1'b0;
                    if (w_hs)  m_axil_wvalid  <= 1'b0;
                    if (aw_done && w_done) begin
                        m_axil_bready <= 1'b1;
                        wait_cnt      <= '0;
                        state         <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (b_hs) begin
                        m_axil_bready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_resp      <= m_axil_bresp;
                        rsp_rdata     <= '0;
                        rsp_timeout   <= 1'b0;
                        state         <= RSP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        m_axil_bready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_resp      <= 2'b10;
                        rsp_rdata     <= '0;
                        rsp_timeout   <= 1'b1;
                        state         <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RD_ADDR: begin
                    if (ar_hs) begin
                        m_axil_arvalid <= 1'b0;
                        m_axil_rready  <= 1'b1;
                        wait_cnt       <= '0;
                        state          <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (r_hs) begin
                        m_axil_rready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_resp      <= m_axil_rresp;
                        rsp_rdata     <= m_axil_rdata;
                        rsp_timeout   <= 1'b0;
                        state         <= RSP;
                    end else if (wait_cnt == WAIT_LAST) begin
                        m_axil_rready <= 1'b0;
                        rsp_valid     <= 1'b1;
                        rsp_resp      <= 2'b10;
                        rsp_rdata     <= '0;
                        rsp_timeout   <= 1'b1;
                        state         <= RSP;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_cfg_master.sv
// tb_axil_cfg_master: randomized transactions against a transaction-level model
// of the expected response, latency and per-channel activity.
module tb_axil_cfg_master;

    localparam int T = 8;

    logic        clk;
    logic        rstn;
    logic        cmd_valid, cmd_ready, cmd_we;
    logic [39:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [39:0] m_axil_awaddr, m_axil_araddr;
    logic [2:0]  m_axil_awprot, m_axil_arprot;
    logic        m_axil_awvalid, m_axil_awready, m_axil_wvalid, m_axil_wready;
    logic [31:0] m_axil_wdata, m_axil_rdata;
    logic [3:0]  m_axil_wstrb;
    logic [1:0]  m_axil_bresp, m_axil_rresp;
    logic        m_axil_bvalid, m_axil_bready, m_axil_arvalid, m_axil_arready;
    logic        m_axil_rvalid, m_axil_rready;

    int total = 0;
    int bad   = 0;

    int          last_lat;
    logic [1:0]  last_resp;
    logic [31:0] last_rdata;
    logic        last_to;

    axil_cfg_master #(
        .AXIL_ADDR_WIDTH(40), .DATA_WIDTH(32), .STRB_WIDTH(4), .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
        .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
        .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
        .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
        .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
        .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
        .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
        .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
        .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: command payload plus how the slave and the response consumer behave.
    typedef struct {
        bit          we;
        logic [39:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_dly, w_dly, ar_dly, b_dly, r_dly, rr_dly;
        logic [1:0]  sresp;
        logic [31:0] srdata;
        bit          eager;
    } plan_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        to;
        int          lat;
        int          waits;
        bit          hs;
    } exp_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the slave answers in wait cycle d (0-based); answers in cycles 0..T-1 count,
    // later ones are pre-empted by a timeout after T wait cycles.
    function automatic exp_t model(input plan_t p);
        exp_t e;
        int   d, a;
        d       = p.we ? p.b_dly : p.r_dly;
        a       = p.we ? ((p.aw_dly > p.w_dly ? p.aw_dly : p.w_dly) + 1) : (p.ar_dly + 1);
        e.hs    = (d < T);
        e.waits = e.hs ? d + 1 : T;
        e.resp  = e.hs ? p.sresp : 2'b10;
        e.rdata = (e.hs && !p.we) ? p.srdata : 32'h0;
        e.to    = !e.hs;
        e.lat   = a + e.waits + 1;
        return e;
    endfunction

    function automatic plan_t mk(input bit we, input logic [39:0] addr, input logic [31:0] wd,
                                 input int aw, input int w, input int ar, input int b, input int r,
                                 input int rr, input logic [1:0] sresp, input logic [31:0] srd,
                                 input bit eager);
        plan_t p;
        p.we = we; p.addr = addr; p.wdata = wd; p.wstrb = 4'hF;
        p.aw_dly = aw; p.w_dly = w; p.ar_dly = ar; p.b_dly = b; p.r_dly = r; p.rr_dly = rr;
        p.sresp = sresp; p.srdata = srd; p.eager = eager;
        return p;
    endfunction

    function automatic plan_t rand_plan();
        plan_t p;
        p.we     = 1'($urandom_range(0, 1));
        p.addr   = {8'($urandom), 32'($urandom)};
        p.wdata  = $urandom;
        p.wstrb  = 4'($urandom);
        p.aw_dly = int'($urandom_range(0, 4));
        p.w_dly  = int'($urandom_range(0, 4));
        p.ar_dly = int'($urandom_range(0, 4));
        p.b_dly  = int'($urandom_range(0, T + 2));
        p.r_dly  = int'($urandom_range(0, T + 2));
        p.rr_dly = int'($urandom_range(0, 3));
        p.sresp  = 2'($urandom);
        p.srdata = $urandom;
        p.eager  = 1'($urandom_range(0, 1));
        return p;
    endfunction

    task automatic drive_cmd(input plan_t p);
        cmd_valid = 1'b1; cmd_we = p.we; cmd_addr = p.addr;
        cmd_wdata = p.wdata; cmd_wstrb = p.wstrb;
    endtask

    task automatic slave_idle();
        m_axil_awready = 0; m_axil_wready = 0; m_axil_arready = 0;
        m_axil_bvalid = 0; m_axil_bresp = 0; m_axil_rvalid = 0; m_axil_rresp = 0;
        m_axil_rdata = 0; rsp_ready = 0;
    endtask

    // Entered at a negedge with the command already on the bus; returns at the negedge
    // where the response handshake is set up for the following posedge.
    task automatic run_txn(input plan_t p, input plan_t nxt, input bit has_nxt);
        exp_t e;
        int   k, awc, wc, arc, bc, rc, rvc, awh, wh, arh, bh, rh, lat;
        bit   bdone, rdone, fin;
        e = model(p);
        awc = 0; wc = 0; arc = 0; bc = 0; rc = 0; rvc = 0;
        awh = 0; wh = 0; arh = 0; bh = 0; rh = 0; lat = -1;
        bdone = 0; rdone = 0; fin = 0;
        chk("cmd_ready_accept", 64'(cmd_ready), 64'(1));
        @(negedge clk);
        cmd_valid = 0; cmd_addr = {8'($urandom), 32'($urandom)}; cmd_wdata = $urandom;
        rsp_ready = 0;
        k = 1;
        while (!fin) begin
            if (m_axil_awvalid) begin
                awc++;
                chk("awaddr", 64'(m_axil_awaddr), 64'(p.addr));
                chk("awprot", 64'(m_axil_awprot), 64'(0));
                m_axil_awready = (awc > p.aw_dly);
                if (m_axil_awready) awh++;
            end else m_axil_awready = 0;
            if (m_axil_wvalid) begin
                wc++;
                chk("wdata", 64'(m_axil_wdata), 64'(p.wdata));
                chk("wstrb", 64'(m_axil_wstrb), 64'(p.wstrb));
                m_axil_wready = (wc > p.w_dly);
                if (m_axil_wready) wh++;
            end else m_axil_wready = 0;
            if (m_axil_arvalid) begin
                arc++;
                chk("araddr", 64'(m_axil_araddr), 64'(p.addr));
                chk("arprot", 64'(m_axil_arprot), 64'(0));
                m_axil_arready = (arc > p.ar_dly);
                if (m_axil_arready) arh++;
            end else m_axil_arready = 0;
            if (m_axil_bready) begin
                bc++;
                m_axil_bvalid = (bc > p.b_dly) && !bdone;
                m_axil_bresp  = m_axil_bvalid ? p.sresp : 2'b00;
                if (m_axil_bvalid) begin bh++; bdone = 1; end
            end else m_axil_bvalid = 0;
            if (m_axil_rready) begin
                rc++;
                m_axil_rvalid = (rc > p.r_dly) && !rdone;
                m_axil_rresp  = m_axil_rvalid ? p.sresp : 2'b00;
                m_axil_rdata  = m_axil_rvalid ? p.srdata : 32'h0;
                if (m_axil_rvalid) begin rh++; rdone = 1; end
            end else m_axil_rvalid = 0;
            if (rsp_valid) begin
                if (rvc == 0) begin
                    lat = k;
                    last_resp = rsp_resp; last_rdata = rsp_rdata; last_to = rsp_timeout;
                    if (p.eager && has_nxt) drive_cmd(nxt);
                end
                rvc++;
                chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                rsp_ready = (rvc > p.rr_dly);
                if (rsp_ready) fin = 1;
            end
            chk("cmd_ready_busy", 64'(cmd_ready), 64'(0));
            if (!fin) begin
                @(negedge clk);
                k++;
                if (k > 300) begin
                    total++; bad++;
                    $display("FAIL txn_budget: no response after %0d cycles, expected %0d", k, e.lat);
                    fin = 1;
                end
            end
        end
        last_lat = lat;
        chk("latency", 64'(lat), 64'(e.lat));
        chk("aw_cycles", 64'(awc), 64'(p.we ? p.aw_dly + 1 : 0));
        chk("aw_hs", 64'(awh), 64'(p.we));
        chk("w_cycles", 64'(wc), 64'(p.we ? p.w_dly + 1 : 0));
        chk("w_hs", 64'(wh), 64'(p.we));
        chk("ar_cycles", 64'(arc), 64'(p.we ? 0 : p.ar_dly + 1));
        chk("ar_hs", 64'(arh), 64'(!p.we));
        chk("bready_cycles", 64'(bc), 64'(p.we ? e.waits : 0));
        chk("b_hs", 64'(bh), 64'(p.we && e.hs));
        chk("rready_cycles", 64'(rc), 64'(p.we ? 0 : e.waits));
        chk("r_hs", 64'(rh), 64'(!p.we && e.hs));
    endtask

    task automatic chk_all_reset(input string tag);
        chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(0));
        chk({tag, "_awvalid"}, 64'(m_axil_awvalid), 64'(0));
        chk({tag, "_wvalid"}, 64'(m_axil_wvalid), 64'(0));
        chk({tag, "_bready"}, 64'(m_axil_bready), 64'(0));
        chk({tag, "_arvalid"}, 64'(m_axil_arvalid), 64'(0));
        chk({tag, "_rready"}, 64'(m_axil_rready), 64'(0));
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
        chk({tag, "_rsp_resp"}, 64'(rsp_resp), 64'(0));
        chk({tag, "_rsp_rdata"}, 64'(rsp_rdata), 64'(0));
        chk({tag, "_rsp_timeout"}, 64'(rsp_timeout), 64'(0));
    endtask

    // Reset pulse while the write sits in WAIT_B: everything clears and no response follows.
    task automatic reset_mid_wait_b();
        plan_t p;
        p = mk(1, 40'h30, 32'hCAFE0001, 0, 0, 0, 100, 0, 0, 2'b00, 32'h0, 0);
        drive_cmd(p);
        @(negedge clk);
        cmd_valid = 0;
        chk("mid_awvalid", 64'(m_axil_awvalid), 64'(1));
        m_axil_awready = 1; m_axil_wready = 1;
        @(negedge clk);
        m_axil_awready = 0; m_axil_wready = 0;
        chk("mid_bready", 64'(m_axil_bready), 64'(1));
        #1 rstn = 0;
        #1 chk_all_reset("mid_rst");
        @(negedge clk);
        chk_all_reset("mid_rst_held");
        rstn = 1;
        @(negedge clk);
        chk("mid_rst_cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (12) begin
            chk("abort_no_rsp", 64'(rsp_valid), 64'(0));
            chk("abort_no_bready", 64'(m_axil_bready), 64'(0));
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        plan_t q[$];
        plan_t p;
        int    n;
        bit    prev_eager;
        rstn = 0; cmd_valid = 0; cmd_we = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        slave_idle();
        repeat (3) @(negedge clk);
        chk_all_reset("rst");
        rstn = 1;
        chk("cmd_ready_before_clk", 64'(cmd_ready), 64'(0));
        @(negedge clk);
        chk("cmd_ready_after_rst", 64'(cmd_ready), 64'(1));

        q.push_back(mk(1, 40'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0));
        q.push_back(mk(1, 40'h14, 32'h0BADF00D, 0, 5, 0, 1, 0, 0, 2'b10, 32'h0, 0));
        q.push_back(mk(0, 40'h20, 32'h0, 0, 0, 2, 0, 4, 0, 2'b00, 32'h12345678, 0));
        q.push_back(mk(0, 40'h24, 32'h0, 0, 0, 0, 0, 20, 1, 2'b00, 32'h55AA55AA, 0));
        q.push_back(mk(0, 40'h28, 32'h0, 0, 0, 0, 0, T - 1, 0, 2'b01, 32'hA5A5A5A5, 0));
        q.push_back(mk(1, 40'h2C, 32'h11112222, 0, 0, 0, T, 0, 0, 2'b00, 32'h0, 0));
        q.push_back(mk(1, 40'h40, 32'h33334444, 1, 0, 0, 2, 0, 10, 2'b11, 32'h0, 1));
        q.push_back(mk(0, 40'h44, 32'h0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h87654321, 0));
        repeat (40) q.push_back(rand_plan());
        n = q.size();

        for (int i = 0; i < n; i++) begin
            prev_eager = (i > 0) && q[i-1].eager;
            if (!prev_eager) begin
                repeat ($urandom_range(0, 2)) begin
                    chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
                    chk("idle_cmd_ready", 64'(cmd_ready), 64'(1));
                    @(negedge clk);
                end
                drive_cmd(q[i]);
            end
            run_txn(q[i], q[(i + 1 < n) ? i + 1 : i], i + 1 < n);
            case (i)
                0: begin
                    chk("lit_wr_lat", 64'(last_lat), 64'(3));
                    chk("lit_wr_resp", 64'(last_resp), 64'(0));
                    chk("lit_wr_to", 64'(last_to), 64'(0));
                end
                1: begin
                    chk("lit_wdly_resp", 64'(last_resp), 64'(2));
                    chk("lit_wdly_lat", 64'(last_lat), 64'(9));
                end
                2: begin
                    chk("lit_rd_rdata", 64'(last_rdata), 64'(32'h12345678));
                    chk("lit_rd_resp", 64'(last_resp), 64'(0));
                    chk("lit_rd_lat", 64'(last_lat), 64'(9));
                end
                3: begin
                    chk("lit_to_lat", 64'(last_lat), 64'(10));
                    chk("lit_to_flag", 64'(last_to), 64'(1));
                    chk("lit_to_resp", 64'(last_resp), 64'(2));
                    chk("lit_to_rdata", 64'(last_rdata), 64'(0));
                end
                4: begin
                    chk("lit_tie_to", 64'(last_to), 64'(0));
                    chk("lit_tie_rdata", 64'(last_rdata), 64'(32'hA5A5A5A5));
                    chk("lit_tie_lat", 64'(last_lat), 64'(10));
                end
                5: chk("lit_bto_flag", 64'(last_to), 64'(1));
                default: ;
            endcase
            @(negedge clk);
            rsp_ready = 0;
        end

        slave_idle();
        reset_mid_wait_b();
        slave_idle();
        p = mk(1, 40'h50, 32'hFEEDFACE, 0, 0, 0, 0, 0, 0, 2'b00, 32'h0, 0);
        drive_cmd(p);
        run_txn(p, p, 0);
        chk("post_rst_lat", 64'(last_lat), 64'(3));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
